ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_host_tx.sv | 190 +++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues request-to-send,
// shifts a command byte out on device clock edges and checks the device ACK.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 200,
  parameter int TIMEOUT_CYCLES = 30000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  output logic       busy
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SEND,
    ACK,
    WAIT_IDLE
  } state_e;

  state_e           state_q, state_d;
  logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             parity_q, parity_d;
  logic             data_oe_q, data_oe_d;
  logic             tx_done_q, tx_done_d;
  logic             tx_error_q, tx_error_d;

  logic clk_s1_q, clk_s2_q, clk_prev_q;
  logic data_s1_q, data_s2_q;
  logic clk_fall;
  logic timeout;

  // Pad synchronizers idle high so reset never fakes a falling edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      data_s1_q  <= 1'b1;
      data_s2_q  <= 1'b1;
    end else begin
      clk_s1_q   <= ps2_clk_in;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      data_s1_q  <= ps2_data_in;
      data_s2_q  <= data_s1_q;
    end
  end

  assign clk_fall = clk_prev_q & ~clk_s2_q;
  assign timeout  = ((state_q == REQ) || (state_q == SEND) || (state_q == ACK) ||
                     (state_q == WAIT_IDLE)) && (to_cnt_q == TO_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      inh_cnt_q  <= '0;
      to_cnt_q   <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      data_oe_q  <= 1'b0;
      tx_done_q  <= 1'b0;
      tx_error_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      inh_cnt_q  <= inh_cnt_d;
      to_cnt_q   <= to_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      data_oe_q  <= data_oe_d;
      tx_done_q  <= tx_done_d;
      tx_error_q <= tx_error_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    inh_cnt_d  = inh_cnt_q;
    to_cnt_d   = to_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    data_oe_d  = data_oe_q;
    tx_done_d  = 1'b0;
    tx_error_d = 1'b0;

    case (state_q)
      IDLE: begin
        data_oe_d = 1'b0;
        if (tx_valid) begin
          shift_d   = tx_data;
          parity_d  = ~^tx_data;
          inh_cnt_d = '0;
          state_d   = INHIBIT;
        end
      end
      INHIBIT: begin
        if (inh_cnt_q == INH_LAST) begin
          to_cnt_d  = '0;
          data_oe_d = 1'b1;
          state_d   = REQ;
        end else begin
          inh_cnt_d = inh_cnt_q + INH_W'(1);
        end
      end
      // First REQ cycle still holds the clock; afterwards wait for it to rise.
      REQ: begin
        to_cnt_d  = to_cnt_q + TO_W'(1);
        bit_cnt_d = 4'd0;
        if ((to_cnt_q != '0) && clk_s2_q) begin
          state_d = SEND;
        end
      end
      SEND: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (clk_fall) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q < 4'd8) begin
            data_oe_d = ~shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
          end else if (bit_cnt_q == 4'd8) begin
            data_oe_d = ~parity_q;
          end else begin
            data_oe_d = 1'b0;
            state_d   = ACK;
          end
        end
      end
      ACK: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (clk_fall) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (data_s2_q) begin
            data_oe_d  = 1'b0;
            tx_error_d = 1'b1;
            state_d    = IDLE;
          end else begin
            state_d = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (clk_s2_q && data_s2_q) begin
          tx_done_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: begin
        data_oe_d = 1'b0;
        state_d   = IDLE;
      end
    endcase

    // Timeout overrides whatever the device did on this cycle.
    if (timeout) begin
      data_oe_d  = 1'b0;
      tx_done_d  = 1'b0;
      tx_error_d = 1'b1;
      state_d    = IDLE;
    end
  end

  assign ps2_clk_oe  = (state_q == INHIBIT) || ((state_q == REQ) && (to_cnt_q == '0));
  assign ps2_data_oe = data_oe_q;
  assign tx_ready    = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign tx_done     = tx_done_q;
  assign tx_error    = tx_error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a PS/2 device model on open-drain lines
// exercises ACK, NACK, timeout, mid-transfer reset and ignored requests.
module tb_ps2_host_tx;

  localparam int HALF = 83;

  logic       clk;
  logic       reset;
  logic       ps2_clk_in, ps2_data_in;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready, tx_done, tx_error, busy;
  logic       dev_clk_low, dev_data_low;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int done_total = 0, err_total = 0;
  int inh_run = 0, inh_len = 0, req_run = 0, req_len = 0;
  int req_cyc = 0, err_cyc = 0;
  logic       done_idle = 1'b0;
  logic [1:0] err_oe = 2'b11;
  logic       err_ready = 1'b0;

  int d0, e0;
  logic [9:0] frame;
  bit got;

  ps2_host_tx dut (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .tx_done    (tx_done),
    .tx_error   (tx_error),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Open-drain bus with pull-ups: either side can pull a line low.
  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  always @(negedge clk) begin
    cyc++;
    if (tx_done) begin
      done_total++;
      done_idle = ps2_clk_in & ps2_data_in;
    end
    if (tx_error) begin
      err_total++;
      err_cyc   = cyc;
      err_oe    = {ps2_clk_oe, ps2_data_oe};
      err_ready = tx_ready;
    end
    if (ps2_clk_oe && !ps2_data_oe) inh_run++;
    else begin
      if (inh_run != 0) inh_len = inh_run;
      inh_run = 0;
    end
    if (ps2_clk_oe && ps2_data_oe) begin
      if (req_run == 0) req_cyc = cyc;
      req_run++;
    end else begin
      if (req_run != 0) req_len = req_run;
      req_run = 0;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] data);
    bit rdy;
    rdy = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (tx_ready) begin
        rdy = 1;
        break;
      end
    end
    checkOutput("ready_before_send", 32'(rdy), 32'd1);
    tx_valid = 1'b1;
    tx_data  = data;
    @(negedge clk);
    tx_valid = 1'b0;
    checkOutput("ready_after_accept", 32'(tx_ready), 32'd0);
    checkOutput("busy_after_accept", 32'(busy), 32'd1);
  endtask

  // Device side: waits for request-to-send, clocks 10 bits (sampled just
  // before each rising edge), then an 11th clock carrying ACK or not.
  task automatic deviceFrame(input bit ack_it, input int abort_edge, input bit poke,
                             output logic [9:0] frm);
    bit rts;
    rts = 0;
    frm = '0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (!ps2_clk_oe && ps2_data_oe) begin
        rts = 1;
        break;
      end
    end
    checkOutput("rts_seen", 32'(rts), 32'd1);
    if (!rts) return;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      if (abort_edge == i + 1) return;
      frm[i] = ps2_data_in;
      dev_clk_low = 1'b0;
      if (poke && i == 3) begin
        tx_valid = 1'b1;
        tx_data  = 8'h00;
        checkOutput("ready_during_send", 32'(tx_ready), 32'd0);
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (HALF - 1) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
    end
    if (ack_it) dev_data_low = 1'b1;
    repeat (5) @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (HALF) @(negedge clk);
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  initial begin
    reset        = 1'b0;
    tx_valid     = 1'b0;
    tx_data      = 8'h00;
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_ready", 32'(tx_ready), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
    checkOutput("rst_data_oe", 32'(ps2_data_oe), 32'd0);
    checkOutput("rst_done", 32'(tx_done), 32'd0);
    checkOutput("rst_error", 32'(tx_error), 32'd0);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    $display("[TB] 0xED with ACK");
    d0 = done_total; e0 = err_total;
    applyStimulus(8'hED);
    deviceFrame(1'b1, 0, 1'b0, frame);
    repeat (20) @(negedge clk);
    checkOutput("ed_inhibit_len", 32'(inh_len), 32'd200);
    checkOutput("ed_req_len", 32'(req_len), 32'd1);
    checkOutput("ed_frame", 32'(frame), 32'h3ED);
    checkOutput("ed_done_count", 32'(done_total - d0), 32'd1);
    checkOutput("ed_error_count", 32'(err_total - e0), 32'd0);
    checkOutput("ed_ready_after", 32'(tx_ready), 32'd1);

    $display("[TB] 0xF4 with ACK");
    d0 = done_total; e0 = err_total;
    applyStimulus(8'hF4);
    deviceFrame(1'b1, 0, 1'b0, frame);
    repeat (20) @(negedge clk);
    checkOutput("f4_frame", 32'(frame), 32'h2F4);
    checkOutput("f4_done_count", 32'(done_total - d0), 32'd1);
    checkOutput("f4_error_count", 32'(err_total - e0), 32'd0);
    checkOutput("f4_done_line_idle", 32'(done_idle), 32'd1);

    $display("[TB] NACK");
    d0 = done_total; e0 = err_total;
    applyStimulus(8'hED);
    deviceFrame(1'b0, 0, 1'b0, frame);
    repeat (20) @(negedge clk);
    checkOutput("nack_error_count", 32'(err_total - e0), 32'd1);
    checkOutput("nack_done_count", 32'(done_total - d0), 32'd0);
    checkOutput("nack_oe_at_error", 32'(err_oe), 32'd0);
    checkOutput("nack_ready_at_error", 32'(err_ready), 32'd1);

    $display("[TB] tx_valid during SEND");
    d0 = done_total; e0 = err_total;
    applyStimulus(8'hED);
    deviceFrame(1'b1, 0, 1'b1, frame);
    repeat (20) @(negedge clk);
    checkOutput("poke_frame", 32'(frame), 32'h3ED);
    checkOutput("poke_done_count", 32'(done_total - d0), 32'd1);
    checkOutput("poke_busy_after", 32'(busy), 32'd0);

    $display("[TB] reset after falling edge 5");
    d0 = done_total; e0 = err_total;
    applyStimulus(8'hED);
    deviceFrame(1'b1, 5, 1'b0, frame);
    checkOutput("abort_data_oe_before", 32'(ps2_data_oe), 32'd1);
    #2;
    reset       = 1'b0;
    dev_clk_low = 1'b0;
    #1;
    checkOutput("abort_clk_oe", 32'(ps2_clk_oe), 32'd0);
    checkOutput("abort_data_oe", 32'(ps2_data_oe), 32'd0);
    @(negedge clk);
    checkOutput("abort_ready", 32'(tx_ready), 32'd1);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("abort_done_count", 32'(done_total - d0), 32'd0);
    checkOutput("abort_error_count", 32'(err_total - e0), 32'd0);
    applyStimulus(8'hF4);
    deviceFrame(1'b1, 0, 1'b0, frame);
    repeat (20) @(negedge clk);
    checkOutput("after_abort_frame", 32'(frame), 32'h2F4);
    checkOutput("after_abort_done_count", 32'(done_total - d0), 32'd1);

    $display("[TB] device never clocks");
    d0 = done_total; e0 = err_total;
    applyStimulus(8'hF4);
    got = 0;
    for (int c = 0; c < 31000; c++) begin
      @(negedge clk);
      if (tx_error) begin
        got = 1;
        break;
      end
    end
    checkOutput("timeout_seen", 32'(got), 32'd1);
    @(negedge clk);
    checkOutput("timeout_latency", 32'(err_cyc - req_cyc), 32'd30000);
    checkOutput("timeout_oe", 32'(err_oe), 32'd0);
    checkOutput("timeout_error_count", 32'(err_total - e0), 32'd1);
    checkOutput("timeout_done_count", 32'(done_total - d0), 32'd0);
    checkOutput("timeout_ready", 32'(tx_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
